// File: rtl/spi_exe_pkg.sv
// Shared types and helpers for the SPI execution unit arithmetic arbiter.
//   arb_state_t : sequencer states (IDLE, EXEC, RESP)
//   sat_max/min : two's-complement extremes for a given width, returned
//                 right-aligned in 32 bits (caller truncates to its width)
package spi_exe_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // 0111..1 for a len-bit signed value
   function automatic logic [31:0] sat_max(input int len);
      return (32'd1 << (len - 1)) - 32'd1;
   endfunction

   // 1000..0 for a len-bit signed value
   function automatic logic [31:0] sat_min(input int len);
      return 32'd1 << (len - 1);
   endfunction

endpackage

// File: rtl/adder.sv
// Signed LEN-bit wrapping adder with signed-overflow flag.
//   i_a, i_b : signed operands
//   o_sum    : a + b, wrapped to LEN bits
//   o_carry  : signed overflow (operands share a sign the result lacks)
module adder #(
   parameter int LEN = 4
) (
   input  logic [LEN-1:0] i_a,
   input  logic [LEN-1:0] i_b,
   output logic [LEN-1:0] o_sum,
   output logic           o_carry
);

   assign o_sum   = i_a + i_b;
   assign o_carry = (i_a[LEN-1] == i_b[LEN-1]) && (o_sum[LEN-1] != i_a[LEN-1]);

endmodule

// File: rtl/adder_arbiter.sv
// Shares one signed LEN-bit adder between N_REQ requesters.
// Round-robin arbiter plus IDLE/EXEC/RESP sequencer: latches the winner's
// operands, adds them, returns a registered (optionally saturated) sum.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : per-requester request
//   i_a, i_b       : per-requester signed operands
//   o_gnt          : one-hot, one-cycle grant pulse
//   o_valid        : one-hot, one-cycle result-valid pulse
//   o_sum, o_ovf   : result and signed-overflow flag, held until next result
//   o_busy         : sequencer not idle
module adder_arbiter
   import spi_exe_pkg::*;
#(
   parameter int LEN   = 4,
   parameter int N_REQ = 2,
   parameter int SAT   = 0
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [N_REQ-1:0]          i_req,
   input  logic [N_REQ-1:0][LEN-1:0] i_a,
   input  logic [N_REQ-1:0][LEN-1:0] i_b,
   output logic [N_REQ-1:0]          o_gnt,
   output logic [N_REQ-1:0]          o_valid,
   output logic [LEN-1:0]            o_sum,
   output logic                      o_ovf,
   output logic                      o_busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [LEN-1:0] SUM_MAX = LEN'(sat_max(LEN));
   localparam logic [LEN-1:0] SUM_MIN = LEN'(sat_min(LEN));

   arb_state_t           state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [LEN-1:0]       a_q, a_d;
   logic [LEN-1:0]       b_q, b_d;
   logic [N_REQ-1:0]     gnt_q, gnt_d;
   logic [N_REQ-1:0]     valid_q, valid_d;
   logic [LEN-1:0]       sum_q, sum_d;
   logic                 ovf_q, ovf_d;

   logic                 pick_found;
   logic [IDX_W-1:0]     pick_idx;
   logic [LEN-1:0]       add_sum;
   logic                 add_ovf;
   logic [LEN-1:0]       sum_sel;

   adder #(.LEN(LEN)) u_adder (
      .i_a     (a_q),
      .i_b     (b_q),
      .o_sum   (add_sum),
      .o_carry (add_ovf)
   );

   // Saturation clamps toward the sign of the operands (both share it on overflow)
   always_comb begin
      sum_sel = add_sum;
      if (SAT != 0 && add_ovf) begin
         sum_sel = a_q[LEN-1] ? SUM_MIN : SUM_MAX;
      end
   end

   // Round-robin search starting at ptr_q, wrapping mod N_REQ
   always_comb begin
      int cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = (int'(ptr_q) + i) % N_REQ;
         if (!pick_found && i_req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      a_d     = a_q;
      b_d     = b_q;
      gnt_d   = '0;
      valid_d = '0;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, RESP: begin
            // RESP arbitrates like IDLE so ops can run back-to-back
            if (pick_found) begin
               a_d             = i_a[pick_idx];
               b_d             = i_b[pick_idx];
               owner_d         = pick_idx;
               gnt_d[pick_idx] = 1'b1;
               ptr_d           = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
               state_d         = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            sum_d            = sum_sel;
            ovf_d            = add_ovf;
            valid_d[owner_q] = 1'b1;
            state_d          = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         gnt_q   <= '0;
         valid_q <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_gnt   = gnt_q;
   assign o_valid = valid_q;
   assign o_sum   = sum_q;
   assign o_ovf   = ovf_q;
   assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

   logic            clk;
   logic            rst_n;
   logic [1:0]      req;
   logic [1:0][3:0] a;
   logic [1:0][3:0] b;

   logic [1:0] w_gnt, w_valid;
   logic [3:0] w_sum;
   logic       w_ovf, w_busy;
   logic [1:0] s_gnt, s_valid;
   logic [3:0] s_sum;
   logic       s_ovf, s_busy;

   int checks = 0;
   int errors = 0;

   adder_arbiter #(.LEN(4), .N_REQ(2), .SAT(0)) u_wrap (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_req   (req),
      .i_a     (a),
      .i_b     (b),
      .o_gnt   (w_gnt),
      .o_valid (w_valid),
      .o_sum   (w_sum),
      .o_ovf   (w_ovf),
      .o_busy  (w_busy)
   );

   adder_arbiter #(.LEN(4), .N_REQ(2), .SAT(1)) u_sat (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_req   (req),
      .i_a     (a),
      .i_b     (b),
      .o_gnt   (s_gnt),
      .o_valid (s_valid),
      .o_sum   (s_sum),
      .o_ovf   (s_ovf),
      .o_busy  (s_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_gnt"},   32'(w_gnt),   32'h0);
      check({tag, "_valid"}, 32'(w_valid), 32'h0);
      check({tag, "_sum"},   32'(w_sum),   32'h0);
      check({tag, "_ovf"},   32'(w_ovf),   32'h0);
      check({tag, "_busy"},  32'(w_busy),  32'h0);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [1:0] exp_gnt;
      logic [1:0] last_gnt;
      rst_n = 1'b0;
      req   = '0;
      a     = '0;
      b     = '0;
      last_gnt = 2'b00;
      exp_gnt  = 2'b00;

      // power-on reset state
      tick();
      check_idle_zero("por");
      rst_n = 1'b1;
      tick();

      // single op: 3 + 2
      a[0] = 4'd3; b[0] = 4'd2; req = 2'b01;
      tick();
      check("single_gnt",   32'(w_gnt),   32'h1);
      check("single_valid0",32'(w_valid), 32'h0);
      check("single_busy",  32'(w_busy),  32'h1);
      $display("op single: gnt=%b", w_gnt);
      req = 2'b00;
      tick();
      check("single_valid", 32'(w_valid), 32'h1);
      check("single_gnt0",  32'(w_gnt),   32'h0);
      check("single_sum",   32'(w_sum),   32'h5);
      check("single_ovf",   32'(w_ovf),   32'h0);
      $display("op single: valid=%b sum=%0d ovf=%b", w_valid, $signed(w_sum), w_ovf);
      tick();
      check("single_idle",  32'(w_busy),  32'h0);
      check("single_hold",  32'(w_sum),   32'h5);

      // asynchronous reset mid-simulation clears outputs without a clock edge
      rst_n = 1'b0;
      #1;
      check_idle_zero("midrst");
      $display("op midreset: sum=%0d busy=%b", w_sum, w_busy);
      tick();
      rst_n = 1'b1;

      // overflow: 7 + 1
      a[0] = 4'd7; b[0] = 4'd1; req = 2'b01;
      tick();
      req = 2'b00;
      tick();
      check("ovf_wrap_sum", 32'(w_sum), 32'h8);
      check("ovf_wrap_ovf", 32'(w_ovf), 32'h1);
      check("ovf_sat_sum",  32'(s_sum), 32'h7);
      check("ovf_sat_ovf",  32'(s_ovf), 32'h1);
      $display("op 7+1: wrap=%0d sat=%0d ovf=%b", $signed(w_sum), $signed(s_sum), w_ovf);
      tick();

      // negative overflow: -8 + -1
      a[0] = 4'b1000; b[0] = 4'b1111; req = 2'b01;
      tick();
      req = 2'b00;
      tick();
      check("neg_wrap_sum", 32'(w_sum), 32'h7);
      check("neg_wrap_ovf", 32'(w_ovf), 32'h1);
      check("neg_sat_sum",  32'(s_sum), 32'h8);
      check("neg_sat_ovf",  32'(s_ovf), 32'h1);
      $display("op -8-1: wrap=%0d sat=%0d ovf=%b", $signed(w_sum), $signed(s_sum), s_ovf);
      tick();

      // tie after reset: requester 0 wins first
      reset_pulse();
      a[0] = 4'd1; b[0] = 4'd1; a[1] = 4'd2; b[1] = 4'd2; req = 2'b11;
      tick();
      check("tie_gnt0", 32'(w_gnt), 32'h1);
      req = 2'b10;
      tick();
      check("tie_valid0", 32'(w_valid), 32'h1);
      check("tie_sum0",   32'(w_sum),   32'h2);
      $display("op tie r0: valid=%b sum=%0d", w_valid, $signed(w_sum));
      tick();
      check("tie_gnt1",   32'(w_gnt),   32'h2);
      check("tie_nvalid", 32'(w_valid), 32'h0);
      req = 2'b00;
      tick();
      check("tie_valid1", 32'(w_valid), 32'h2);
      check("tie_sum1",   32'(w_sum),   32'h4);
      $display("op tie r1: valid=%b sum=%0d", w_valid, $signed(w_sum));
      tick();
      check("tie_idle", 32'(w_busy), 32'h0);

      // fairness: both held high, grants alternate every other cycle
      reset_pulse();
      a[0] = 4'd1; b[0] = 4'd0; a[1] = 4'd2; b[1] = 4'd0; req = 2'b11;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c % 2 == 1) begin
            exp_gnt = (((c - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
            check("fair_gnt",   32'(w_gnt),   32'(exp_gnt));
            check("fair_nval",  32'(w_valid), 32'h0);
            last_gnt = exp_gnt;
         end else begin
            check("fair_ngnt",  32'(w_gnt),   32'h0);
            check("fair_valid", 32'(w_valid), 32'(last_gnt));
            check("fair_sum",   32'(w_sum),   (last_gnt == 2'b01) ? 32'h1 : 32'h2);
         end
         $display("op fair c=%0d: gnt=%b valid=%b sum=%0d", c, w_gnt, w_valid, $signed(w_sum));
      end
      req = 2'b00;
      tick();
      tick();
      check("fair_idle", 32'(w_busy), 32'h0);

      // reset during the grant cycle discards the op
      reset_pulse();
      a[0] = 4'd5; b[0] = 4'd1; req = 2'b01;
      tick();
      check("exrst_gnt", 32'(w_gnt), 32'h1);
      req   = 2'b00;
      rst_n = 1'b0;
      #1;
      check_idle_zero("exrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("exrst_nvalid", 32'(w_valid), 32'h0);
         check("exrst_sum",    32'(w_sum),   32'h0);
         $display("op exrst c=%0d: valid=%b sum=%0d", c, w_valid, $signed(w_sum));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
